// File: rtl/led_ripple_monitor.sv
// Passive checker for a one-hot rippling LED bus: locks onto the lit LED, validates
// each rotate-left step and its dwell time, counts steps and records the first fault.
module led_ripple_monitor #(
  parameter int unsigned MIN_DWELL = 2,
  parameter int unsigned MAX_DWELL = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  led,
  input  logic        clr,
  output logic [2:0]  pos,
  output logic        locked,
  output logic        step,
  output logic [15:0] step_count,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_PATTERN = 2'b01;
  localparam logic [1:0] CODE_FAST    = 2'b10;
  localparam logic [1:0] CODE_STALL   = 2'b11;

  localparam logic [31:0] MIN_DWELL_W = 32'(MIN_DWELL);
  localparam logic [31:0] MAX_DWELL_W = 32'(MAX_DWELL);

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] index_of(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  led_q;
  logic [7:0]  prev_q, prev_d;
  logic [31:0] dwell_q, dwell_d;
  logic [2:0]  pos_q, pos_d;
  logic        locked_q, locked_d;
  logic        step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    pos_d    = pos_q;
    locked_d = locked_q;
    step_d   = 1'b0;
    cnt_d    = cnt_q;
    err_d    = err_q;
    code_d   = code_q;

    // clr takes priority over any step or error detected in the same cycle
    if (clr) begin
      state_d  = IDLE;
      err_d    = 1'b0;
      code_d   = CODE_NONE;
      locked_d = 1'b0;
      dwell_d  = 32'd0;
      cnt_d    = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_onehot(led_q)) begin
            prev_d  = led_q;
            pos_d   = index_of(led_q);
            dwell_d = 32'd1;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (led_q == prev_q) begin
            if (dwell_q == MAX_DWELL_W) begin
              state_d = FAULT;
              err_d   = 1'b1;
              code_d  = CODE_STALL;
            end else begin
              dwell_d = dwell_q + 32'd1;
            end
          end else if (led_q == rotl(prev_q)) begin
            if (dwell_q >= MIN_DWELL_W) begin
              step_d   = 1'b1;
              cnt_d    = cnt_q + 16'd1;
              locked_d = 1'b1;
              prev_d   = led_q;
              pos_d    = index_of(led_q);
              dwell_d  = 32'd1;
            end else begin
              state_d = FAULT;
              err_d   = 1'b1;
              code_d  = CODE_FAST;
            end
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
            code_d  = CODE_PATTERN;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      led_q    <= 8'h00;
      prev_q   <= 8'h00;
      dwell_q  <= 32'd0;
      pos_q    <= 3'd0;
      locked_q <= 1'b0;
      step_q   <= 1'b0;
      cnt_q    <= 16'd0;
      err_q    <= 1'b0;
      code_q   <= CODE_NONE;
    end else begin
      state_q  <= state_d;
      led_q    <= led;
      prev_q   <= prev_d;
      dwell_q  <= dwell_d;
      pos_q    <= pos_d;
      locked_q <= locked_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign pos        = pos_q;
  assign locked     = locked_q;
  assign step       = step_q;
  assign step_count = cnt_q;
  assign err        = err_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_led_ripple_monitor.sv
// Directed plus randomized bench for led_ripple_monitor against a cycle-level
// behavioural model built from the step/dwell rules.
module tb_led_ripple_monitor;

  localparam int MIN = 2;
  localparam int MAX = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  led;
  logic        clr;
  logic [2:0]  pos;
  logic        locked;
  logic        step;
  logic [15:0] step_count;
  logic        err;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;

  led_ripple_monitor #(.MIN_DWELL(MIN), .MAX_DWELL(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .led(led), .clr(clr), .pos(pos), .locked(locked),
    .step(step), .step_count(step_count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Reference: 0 = searching, 1 = following, 2 = faulted
  int m_phase, m_sample, m_lit, m_held, m_pos, m_locked, m_step, m_cnt, m_err, m_code;

  function automatic int next_lit(input int v);
    return (v == 128) ? 1 : v * 2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sample = 0; m_lit = 0; m_held = 0; m_pos = 0;
    m_locked = 0; m_step = 0; m_cnt = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_fault(input int code);
    m_phase = 2; m_err = 1; m_code = code;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("step", 32'(step), 32'(m_step));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("step_count", 32'(step_count), 32'(m_cnt));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("pos", 32'(pos), 32'(m_pos));
  endtask

  task automatic tick();
    int s;
    s = m_sample;
    m_step = 0;
    if (clr) begin
      m_phase = 0; m_err = 0; m_code = 0; m_locked = 0; m_held = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if ($countones(8'(s)) == 1) begin
        m_lit = s; m_pos = $clog2(s); m_held = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (s == m_lit) begin
        if (m_held == MAX) model_fault(3);
        else m_held++;
      end else if (s == next_lit(m_lit)) begin
        if (m_held >= MIN) begin
          m_step = 1; m_cnt = (m_cnt + 1) % 65536; m_locked = 1;
          m_lit = s; m_pos = $clog2(s); m_held = 1;
        end else begin
          model_fault(2);
        end
      end else begin
        model_fault(1);
      end
    end
    m_sample = int'(led);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int cur, act, v, stepcnt_seen, first_step_tick;

  initial begin
    rst_n = 1'b0; led = 8'h00; clr = 1'b0;
    model_reset();
    #12;
    check_outputs();
    chk("reset_step_count", 32'(step_count), 32'h0);
    rst_n = 1'b1;

    // Full ripple: 0x01 then eight rotate-left steps, 4 clocks each
    led = 8'h01;
    hold(4);
    first_step_tick = -1;
    cur = 1;
    for (int k = 0; k < 8; k++) begin
      cur = next_lit(cur);
      led = 8'(cur);
      for (int t = 0; t < 4; t++) begin
        tick();
        if (k == 0 && step === 1'b1 && first_step_tick < 0) first_step_tick = t + 1;
      end
    end
    chk("first_step_latency", 32'(first_step_tick), 32'd2);
    chk("ripple_count", 32'(step_count), 32'd8);
    chk("ripple_locked", 32'(locked), 32'd1);
    chk("ripple_err", 32'(err), 32'd0);
    chk("ripple_pos", 32'(pos), 32'd0);

    // Advance to 0x10 then jump two positions
    for (int k = 0; k < 4; k++) begin
      cur = next_lit(cur);
      led = 8'(cur);
      hold(4);
    end
    stepcnt_seen = int'(step_count);
    led = 8'h40;
    hold(4);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_code", 32'(err_code), 32'd1);
    chk("bad_frozen", 32'(step_count), 32'(stepcnt_seen));
    clr = 1'b1;
    tick();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_count", 32'(step_count), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    led = 8'h00;
    tick();
    clr = 1'b0;
    tick();

    // Too-fast step
    led = 8'h01;
    tick();
    led = 8'h02;
    hold(4);
    chk("fast_code", 32'(err_code), 32'd2);
    chk("fast_nostep", 32'(step_count), 32'd0);

    // Stall then later changes ignored
    clr = 1'b1; led = 8'h00;
    hold(2);
    clr = 1'b0;
    led = 8'h08;
    hold(6);
    chk("stall_not_yet", 32'(err), 32'd0);
    tick();
    chk("stall_code", 32'(err_code), 32'd3);
    led = 8'h10; tick();
    led = 8'hA5; tick();
    chk("stall_sticky", 32'(err_code), 32'd3);

    // Zero and multi-hot in IDLE are ignored
    clr = 1'b1; led = 8'h00;
    hold(2);
    clr = 1'b0;
    hold(3);
    led = 8'h03;
    hold(10);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_locked", 32'(locked), 32'd0);

    // Randomized segments
    clr = 1'b1; led = 8'h00;
    hold(2);
    clr = 1'b0;
    cur = 1 << $urandom_range(0, 7);
    led = 8'(cur);
    hold($urandom_range(MIN, MAX));
    for (int seg = 0; seg < 400; seg++) begin
      act = $urandom_range(0, 19);
      if (m_err != 0 && $urandom_range(0, 2) == 0) act = 2;
      if (act == 0) begin
        v = $urandom_range(0, 255);
        led = 8'(v);
        hold($urandom_range(1, 3));
      end else if (act == 1) begin
        cur = next_lit(cur);
        led = 8'(cur);
        tick();
        cur = next_lit(cur);
        led = 8'(cur);
        hold(2);
      end else if (act == 2) begin
        clr = 1'b1;
        hold($urandom_range(1, 2));
        clr = 1'b0;
        led = 8'(cur);
        hold($urandom_range(MIN, MAX));
      end else if (act == 3) begin
        hold(MAX + 2);
      end else begin
        cur = next_lit(cur);
        led = 8'(cur);
        hold($urandom_range(MIN, MAX));
      end
    end

    // Asynchronous reset while tracking
    clr = 1'b1; led = 8'h00;
    hold(2);
    clr = 1'b0;
    led = 8'h04; hold(3);
    led = 8'h08; hold(3);
    chk("pre_rst_locked", 32'(locked), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_pos", 32'(pos), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    led = 8'h20;
    hold(4);
    led = 8'h40;
    hold(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_ripple_monitor.md
# led_ripple_monitor

Passive checker on the 8-bit LED bus driven by the rippling-LED generator. Samples the bus every clock, locks onto the single lit LED, confirms each step is a one-position rotate-left with legal dwell time, and counts completed steps. Raises a sticky, coded error on any illegal pattern, too-fast step or stall. Sits beside the generator in board builds and benches; it never drives the LEDs.

## Interface
- MIN_DWELL, 2: minimum cycles a position must be held before a legal step.
- MAX_DWELL, 1000: maximum cycles a position may be held; exceeding this is a stall.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- led  input  8  LED bus under observation.
- clr  input  1  synchronous clear of errors, lock and counters.
- pos  output  3  index of the lit LED currently tracked.
- locked  output  1  high after the first legal step since reset/clear.
- step  output  1  one-cycle pulse per legal step.
- step_count  output  16  legal steps since reset/clear; wraps 0xFFFF->0x0000.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 bad pattern, 10 too fast, 11 stall.

## Operation
- Reset (async, rst_n low): led_q=0, prev=0, dwell=0, pos=0, locked=0, step=0, step_count=0, err=0, err_code=00, state IDLE.
- Input stage: led registered into led_q every edge; all decisions use led_q.
- Legal next pattern: rotate-left of prev, i.e. bit i -> bit i+1, bit 7 -> bit 0.
- IDLE: if led_q one-hot -> prev=led_q, pos=index, dwell=1, go TRACK. Zero or multi-hot -> stay IDLE, no error.
- TRACK, led_q == prev: dwell+1. If dwell already == MAX_DWELL -> FAULT, code 11.
- TRACK, led_q == rotl(prev): if dwell >= MIN_DWELL -> step=1, step_count+1, locked=1, prev=led_q, pos=index, dwell=1; else -> FAULT, code 10.
- TRACK, any other value (incl. zero, multi-hot, rotate-right) -> FAULT, code 01.
- FAULT: err=1, err_code held, step=0, counters frozen, locked held. Leaves only on clr.
- clr (any state): next edge -> IDLE, err=0, err_code=00, locked=0, dwell=0, step_count=0, step=0. clr beats a same-cycle error or step.
- Only first error is recorded; later anomalies in FAULT ignored.
- dwell: 32-bit, never exceeds MAX_DWELL+0 in TRACK (stall caught at the boundary).

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency: led change sampled at edge N into led_q; step/err/pos update at edge N+1, visible during cycle after N+1.
- Dwell measured in led_q cycles: position held K clocks on led gives dwell K at the step decision.
- step width exactly one clock; back-to-back steps impossible when MIN_DWELL >= 2.
- Stall: err asserts at the edge where led_q has been constant for MAX_DWELL+1 sampled cycles.
- rst_n assertion mid-operation clears everything immediately; deassertion synchronous use only (bench releases away from clk edge).

## Test plan
- Reset then led=0x01 held 4 clk, then 0x02, 0x04 ... 0x80, 0x01 each held 4 clk -> first step pulse 2 edges after 0x02 applied, 8 steps, step_count=8, locked=1, err=0, pos=0 at end.
- Locked on 0x10 (dwell 4), drive 0x40 -> err=1, err_code=01, step_count frozen; assert clr 1 clk -> err=0, state IDLE, step_count=0.
- 0x01 held 1 clk then 0x02 (MIN_DWELL=2) -> err_code=10, no step pulse.
- 0x08 held with MAX_DWELL=5 -> err_code=11 after 6th sampled cycle; further led changes leave err_code=11.
- Force step_count to 0xFFFF via 65536 legal steps (MIN_DWELL=2) -> wraps to 0x0000, err=0.
- Idle with led=0x00 then 0x03 for 10 clk -> stays IDLE, err=0, locked=0; mid-TRACK pull rst_n low -> all outputs reset values same cycle.
